// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: runs a buffered RPN program on an external stack ALU,
// enforcing stack-depth legality and returning the final popped value.
module stack_alu_sequencer #(
    parameter int N           = 32,
    parameter int PROG_DEPTH  = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_clr,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [2:0]                    load_opcode,
    input  logic [N-1:0]                  load_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [N-1:0]                  result,
    output logic                          result_valid,
    output logic                          ovf_flag,
    output logic                          err,
    output logic [2:0]                    err_code,
    output logic [$clog2(PROG_DEPTH)-1:0] err_pc,
    output logic                          alu_clr,
    output logic [2:0]                    alu_opcode,
    output logic [N-1:0]                  alu_input_data,
    input  logic [N-1:0]                  alu_output_data,
    input  logic                          alu_overflow
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [CW-1:0] PD = CW'(PROG_DEPTH);
    localparam logic [DW-1:0] SD = DW'(STACK_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_EXEC, S_POP, S_CAPT, S_DONE, S_ERR} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_op   [PROG_DEPTH];
    logic [N-1:0]    r_data [PROG_DEPTH];
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_pc;
    logic [DW-1:0]   r_depth;
    logic            r_arith_d;
    logic [N-1:0]    r_result;
    logic            r_rv, r_ovf, r_err;
    logic [2:0]      r_err_code;
    logic [AW-1:0]   r_err_pc;

    logic [2:0]      w_op;
    logic            w_push, w_arith, w_pop;
    logic            w_fault_ovf, w_fault_udf, w_fault;
    logic [DW-1:0]   w_depth_nx;
    logic            w_last, w_issue, w_load, w_start;
    logic [2:0]      w_err_code;
    logic [AW-1:0]   w_err_pc;

    always_comb begin
        w_op        = r_op[r_pc];
        w_push      = w_op == 3'b110;
        w_arith     = w_op[2:1] == 2'b10;
        w_pop       = w_op == 3'b111;
        w_fault_ovf = w_push && r_depth == SD;
        w_fault_udf = (w_arith && r_depth < DW'(2)) || (w_pop && r_depth == '0);
        w_fault     = w_fault_ovf || w_fault_udf;
        w_depth_nx  = w_push ? r_depth + DW'(1) : (w_arith || w_pop) ? r_depth - DW'(1) : r_depth;
        w_last      = {1'b0, r_pc} == r_count - CW'(1);
        w_issue     = r_state == S_EXEC && !w_fault;
        w_load      = load_valid && load_ready && !prog_clr;
        w_start     = r_state == S_IDLE && start && !prog_clr;
        w_err_code  = r_state == S_IDLE ? 3'd1 : w_fault_ovf ? 3'd3 : w_fault_udf ? 3'd2 : 3'd4;
        w_err_pc    = r_state == S_IDLE ? '0 : w_fault ? r_pc : r_count[AW-1:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? (r_count == '0 ? S_ERR : S_CLEAR) : S_IDLE;
            S_CLEAR: w_next = S_EXEC;
            S_EXEC:  w_next = w_fault ? S_ERR : !w_last ? S_EXEC : w_depth_nx == DW'(1) ? S_POP : S_ERR;
            S_POP:   w_next = S_CAPT;
            S_CAPT:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_pc       <= '0;
            r_depth    <= '0;
            r_arith_d  <= 1'b0;
            r_result   <= '0;
            r_rv       <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_err_pc   <= '0;
        end else begin
            r_state   <= w_next;
            r_arith_d <= w_issue && w_arith;
            if (r_arith_d)
                r_ovf <= r_ovf | alu_overflow;
            if (r_state == S_IDLE && prog_clr) begin
                r_count <= '0;
                r_rv    <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_load) begin
                r_count <= r_count + CW'(1);
            end
            if (w_start) begin
                r_rv       <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= '0;
                r_err_pc   <= '0;
                r_ovf      <= 1'b0;
            end
            if (r_state == S_CLEAR) begin
                r_pc    <= '0;
                r_depth <= '0;
            end
            if (w_issue) begin
                r_pc    <= r_pc + AW'(1);
                r_depth <= w_depth_nx;
            end
            if (r_state == S_CAPT)
                r_result <= alu_output_data;
            if (w_next == S_DONE)
                r_rv <= 1'b1;
            if (w_next == S_ERR) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
                r_err_pc   <= w_err_pc;
            end
        end
    end

    // Program storage needs no reset; count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_op[r_count[AW-1:0]]   <= load_opcode;
            r_data[r_count[AW-1:0]] <= load_data;
        end
    end

    assign load_ready     = r_state == S_IDLE && r_count < PD;
    assign busy           = r_state != S_IDLE;
    assign done           = r_state == S_DONE;
    assign alu_clr        = r_state == S_CLEAR;
    assign alu_opcode     = w_issue ? w_op : r_state == S_POP ? 3'b111 : 3'b000;
    assign alu_input_data = w_issue ? r_data[r_pc] : '0;
    assign result         = r_result;
    assign result_valid   = r_rv;
    assign ovf_flag       = r_ovf;
    assign err            = r_err;
    assign err_code       = r_err_code;
    assign err_pc         = r_err_pc;
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb_stack_alu_sequencer: scoreboard bench with a behavioural stack ALU attached.
module tb_stack_alu_sequencer;
    localparam int N  = 32;
    localparam int PD = 16;
    localparam int SD = 8;

    logic          clk = 0, rst = 1;
    logic          prog_clr = 0, load_valid = 0, start = 0;
    logic          load_ready, busy, done, result_valid, ovf_flag, err, alu_clr;
    logic [2:0]    load_opcode = 0, err_code, alu_opcode;
    logic [N-1:0]  load_data = 0, result, alu_input_data, alu_output_data;
    logic [3:0]    err_pc;
    logic          alu_overflow;

    stack_alu_sequencer #(.N(N), .PROG_DEPTH(PD), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .prog_clr(prog_clr), .load_valid(load_valid),
        .load_ready(load_ready), .load_opcode(load_opcode), .load_data(load_data),
        .start(start), .busy(busy), .done(done), .result(result),
        .result_valid(result_valid), .ovf_flag(ovf_flag), .err(err),
        .err_code(err_code), .err_pc(err_pc), .alu_clr(alu_clr),
        .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
        .alu_output_data(alu_output_data), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural stack ALU matching the fixed opcode contract
    logic [N-1:0]       stk [32];
    int                 sp, i1, i2;
    logic signed [63:0] m_sum, m_prod;
    always_comb begin
        i1 = sp > 0 ? sp - 1 : 0;
        i2 = sp > 1 ? sp - 2 : 0;
        m_sum  = $signed(stk[i2]) + $signed(stk[i1]);
        m_prod = $signed(stk[i2]) * $signed(stk[i1]);
    end
    always @(posedge clk) begin
        if (rst || alu_clr) begin
            sp <= 0;
            alu_output_data <= '0;
            alu_overflow <= 1'b0;
        end else begin
            case (alu_opcode)
                3'b110: begin stk[sp] <= alu_input_data; sp <= sp + 1; alu_overflow <= 1'b0; end
                3'b100: begin stk[i2] <= m_sum[31:0]; sp <= sp - 1;
                              alu_overflow <= m_sum > 64'sd2147483647 || m_sum < -64'sd2147483648; end
                3'b101: begin stk[i2] <= m_prod[31:0]; sp <= sp - 1;
                              alu_overflow <= m_prod > 64'sd2147483647 || m_prod < -64'sd2147483648; end
                3'b111: begin alu_output_data <= stk[i1]; sp <= sp - 1; alu_overflow <= 1'b0; end
                default: alu_overflow <= 1'b0;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [3:0] pc;
        logic [31:0] res;
        bit         ovf;
        int         cyc;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (!rst && (done || (err && busy))) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: done=%0b err=%0b, expected no completion", done, err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_vs_err", {63'd0, done}, {63'd0, !e.is_err});
                if (e.is_err) begin
                    chk("err_code", {61'd0, err_code}, {61'd0, e.code});
                    chk("err_pc", {60'd0, err_pc}, {60'd0, e.pc});
                end else begin
                    chk("result", {32'd0, result}, {32'd0, e.res});
                    chk("ovf_flag", {63'd0, ovf_flag}, {63'd0, e.ovf});
                    chk("result_valid", {63'd0, result_valid}, 64'd1);
                    chk("err_low_on_done", {63'd0, err}, 64'd0);
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic ld(input logic [2:0] op, input logic [N-1:0] d);
        load_valid = 1; load_opcode = op; load_data = d;
        @(posedge clk); #1;
        load_valid = 0;
    endtask

    task automatic clr();
        prog_clr = 1;
        @(posedge clk); #1;
        prog_clr = 0;
    endtask

    task automatic go(input bit is_err, input logic [2:0] code, input logic [3:0] pc,
                      input logic [31:0] res, input bit ovf, input int p, input bit poke);
        exp_t e;
        e.is_err = is_err; e.code = code; e.pc = pc; e.res = res; e.ovf = ovf;
        e.cyc = cyc + p + 4;
        q.push_back(e);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        if (poke) begin
            load_valid = 1; load_opcode = 3'b110; load_data = 32'd99;
            repeat (3) @(posedge clk);
            #1 load_valid = 0;
        end
        for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: %0d outstanding, expected 0", q.size());
            q.delete();
        end
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_done", {63'd0, done}, 0);
        chk("rst_err", {60'd0, err, err_code}, 0);
        chk("rst_rv_ovf", {62'd0, result_valid, ovf_flag}, 0);
        chk("rst_result", {32'd0, result}, 0);
        chk("rst_alu", {28'd0, alu_clr, alu_opcode, alu_input_data}, 0);
        chk("rst_load_ready", {63'd0, load_ready}, 1);

        // signed add wrap
        ld(3'b110, 32'h7FFF_FFFF); ld(3'b110, 32'd1); ld(3'b100, 0);
        go(0, 0, 0, 32'h8000_0000, 1, 3, 0);
        chk("rv_held", {63'd0, result_valid}, 1);
        chk("busy_after_done", {63'd0, busy}, 0);

        // multiply wrap, then rerun without reload
        clr();
        chk("clr_rv", {63'd0, result_valid}, 0);
        ld(3'b110, 32'd1000000000); ld(3'b110, 32'd5); ld(3'b101, 0);
        go(0, 0, 0, 32'd705032704, 1, 3, 0);
        go(0, 0, 0, 32'd705032704, 1, 3, 0);

        // mixed program; load attempts while busy must be dropped
        clr();
        ld(3'b110, 32'd22); ld(3'b110, 32'd36); ld(3'b100, 0); ld(3'b110, 32'd8); ld(3'b101, 0);
        go(0, 0, 0, 32'd464, 0, 5, 1);
        go(0, 0, 0, 32'd464, 0, 5, 0);

        clr(); ld(3'b110, 32'd1); ld(3'b100, 0);
        go(1, 3'd2, 4'd1, 0, 0, 2, 0);
        chk("err_held", {63'd0, err}, 1);
        chk("no_rv_on_err", {63'd0, result_valid}, 0);

        clr(); ld(3'b110, 32'd1); ld(3'b110, 32'd2);
        go(1, 3'd4, 4'd2, 0, 0, 2, 0);

        clr();
        for (int i = 0; i <= SD; i++) ld(3'b110, 32'(i));
        go(1, 3'd3, 4'(SD), 0, 0, SD + 1, 0);

        // prog_clr beats start in the same cycle
        prog_clr = 1; start = 1;
        @(posedge clk); #1;
        prog_clr = 0; start = 0;
        chk("clr_start_err_cleared", {63'd0, err}, 0);
        @(posedge clk); #1;
        chk("clr_start_no_run", {63'd0, busy}, 0);
        go(1, 3'd1, 4'd0, 0, 0, 0, 0);

        // full buffer: push, push, add, 13 NOPs, then a dropped extra write
        clr();
        ld(3'b110, 32'd1); ld(3'b110, 32'd2); ld(3'b100, 0);
        for (int i = 0; i < 13; i++) ld(3'(i % 4), 32'(i));
        chk("full_load_ready", {63'd0, load_ready}, 0);
        ld(3'b111, 0);
        go(0, 0, 0, 32'd3, 0, 16, 0);

        // reset in the middle of execution
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst_busy_done", {62'd0, busy, done}, 0);
        chk("midrst_err", {60'd0, err, err_code}, 0);
        chk("midrst_result", {31'd0, result_valid, result}, 0);
        chk("midrst_alu", {28'd0, alu_clr, alu_opcode, alu_input_data}, 0);
        chk("midrst_load_ready", {63'd0, load_ready}, 1);
        repeat (3) @(posedge clk);
        #1;
        go(1, 3'd1, 4'd0, 0, 0, 0, 0);
        ld(3'b110, 32'd22); ld(3'b110, 32'd36); ld(3'b100, 0); ld(3'b110, 32'd8); ld(3'b101, 0);
        go(0, 0, 0, 32'd464, 0, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
